axi_traffic_master: RTL
=======================

Name: axi_traffic_master

Overview:
- AXI4 initiator (manager) for driving AXI responders in the NoC, e.g. RAM endpoints, during bring-up and PMU characterisation.
- Accepts one command at a time over a valid/ready command port.
- A write command issues one INCR write burst with generated data. A read command issues one INCR read burst and checks the returned data against the same generator.
- Connects to the fabric through the shared `axis_mosi_t`/`axis_miso_t` structs, which it drives as master.

Parameters:
- ID_W_WIDTH, 4, AWID/BID width
- ID_R_WIDTH, 4, ARID/RID width
- ADDR_WIDTH, 16, byte address width
- DATA_WIDTH, 32, data bus width
- BYTE_WIDTH, 8, strobe granularity; WSTRB width = DATA_WIDTH/BYTE_WIDTH

Ports:
- clk_in  input  1  clock, all logic on rising edge
- rst_in  input  1  asynchronous active-high reset
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  command accepted when valid&ready
- cmd_write_i  input  1  1 = write burst, 0 = read-and-check burst
- cmd_addr_i  input  ADDR_WIDTH  burst start address, aligned to DATA_WIDTH/8
- cmd_len_i  input  8  AxLEN (beats-1)
- cmd_id_i  input  max(ID_W_WIDTH,ID_R_WIDTH)  transaction ID, truncated per channel
- cmd_seed_i  input  DATA_WIDTH  data pattern seed
- out_mosi_o  output  axis_mosi_t  AW/W/AR channels plus BREADY/RREADY
- out_miso_i  input  axis_miso_t  AWREADY/WREADY/ARREADY and the B/R channels
- done_o  output  1  one-cycle pulse when a command completes
- resp_o  output  2  worst response of the last command (max of BRESP or all RRESP)
- err_cnt_o  output  16  data mismatch count of the last read, saturating
- proto_err_o  output  1  last command saw an ID mismatch or misplaced RLAST

Behaviour:
- Reset state: FSM in IDLE. All of the following are 0: every VALID/READY, cmd_ready_o, done_o, resp_o, err_cnt_o, proto_err_o, and the beat counter. Reset asserted mid-burst drops all VALIDs asynchronously; no completion is reported.
- Fixed address fields:
  - AxBURST = INCR.
  - AxSIZE = log2(DATA_WIDTH/8).
  - WSTRB all ones.
  - AxLEN = latched cmd_len_i.
- Pattern: beat k carries data = seed + k, modulo 2^DATA_WIDTH, with k counted from 0.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, latch addr/len/id/seed/write, clear err_cnt_o, resp_o and proto_err_o, then go to AW (write) or AR (read).
  - cmd_ready_o is 0 in every other state.
- AW / AR:
  - VALID is asserted the cycle after command acceptance.
  - Payload is held stable until READY. VALID never drops before the handshake.
  - After the handshake, go to W or R respectively.
- W:
  - WVALID = 1. WDATA = seed + k. WLAST = (k == len).
  - k increments on each WVALID&WREADY. A stall (WREADY low) holds data and k.
  - Handshake of the last beat goes to B. W never starts before the AW handshake.
- B:
  - BREADY = 1.
  - On BVALID: resp_o = BRESP; proto_err_o set if BID != latched ID; go to DONE.
- R:
  - RREADY = 1, held continuously.
  - Each RVALID beat k:
    - RDATA != seed + k increments err_cnt_o, saturating at 16'hFFFF.
    - resp_o = max(resp_o, RRESP).
    - proto_err_o is set if RID != ID, or if RLAST != (k == len).
  - The burst ends on the first beat with RLAST = 1, even if that beat is early. Beats beyond len without RLAST are still checked against seed + k, with k continuing to count.
- DONE: done_o = 1 for exactly one cycle, then return to IDLE. Status outputs hold until the next command is accepted.
- Latency (zero-wait responder):
  - Command handshake to AWVALID/ARVALID: 1 cycle.
  - Write of len = 0: AW, W, B, DONE. done_o is asserted 1 cycle after the B handshake.
- Only one transaction is outstanding. A new command is not accepted until after the DONE cycle.

Test Plan:
- Write addr 0x0040, len 3, seed 0x1000, responder always ready -> AWLEN = 3. W beats 0x1000..0x1003 with WLAST only on beat 3. BRESP OKAY gives resp_o = 0, then a single done_o pulse.
- Read back the same region, seed 0x1000 -> err_cnt_o = 0, proto_err_o = 0, resp_o = 0, done_o one pulse.
- Read with seed 0x1000 against memory holding 0x1000, 0xDEAD, 0x1002, 0xBEEF -> err_cnt_o = 2.
- Random AWREADY/WREADY/ARREADY stalls and RVALID gaps on a len = 7 burst -> payload stable during every stall, no beat lost or duplicated, 8 W beats total.
- Responder returns RLAST on beat 1 of a len = 3 read -> burst ends, proto_err_o = 1, done_o pulses. Also: BID mismatch -> proto_err_o = 1. SLVERR on beat 2 of a read -> resp_o = 2'b10.
- Assert rst_in during the W phase -> WVALID/AWVALID low immediately, no done_o. After release, cmd_ready_o = 1 and a new write completes correctly.

Source files
------------

// File: rtl/axi_traffic_master.sv
// AXI4 traffic initiator: one INCR write burst of seed+k data per write command,
// or one INCR read burst whose returned data is checked against the same pattern.

package axis_pkg;
    localparam int AXIS_ID_W_WIDTH = 4;
    localparam int AXIS_ID_R_WIDTH = 4;
    localparam int AXIS_ADDR_WIDTH = 16;
    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_BYTE_WIDTH = 8;
    localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / AXIS_BYTE_WIDTH;

    typedef struct packed {
        logic [AXIS_ID_W_WIDTH-1:0] aw_id;
        logic [AXIS_ADDR_WIDTH-1:0] aw_addr;
        logic [7:0]                 aw_len;
        logic [2:0]                 aw_size;
        logic [1:0]                 aw_burst;
        logic                       aw_valid;
        logic [AXIS_DATA_WIDTH-1:0] w_data;
        logic [AXIS_STRB_WIDTH-1:0] w_strb;
        logic                       w_last;
        logic                       w_valid;
        logic                       b_ready;
        logic [AXIS_ID_R_WIDTH-1:0] ar_id;
        logic [AXIS_ADDR_WIDTH-1:0] ar_addr;
        logic [7:0]                 ar_len;
        logic [2:0]                 ar_size;
        logic [1:0]                 ar_burst;
        logic                       ar_valid;
        logic                       r_ready;
    } axis_mosi_t;

    typedef struct packed {
        logic                       aw_ready;
        logic                       w_ready;
        logic [AXIS_ID_W_WIDTH-1:0] b_id;
        logic [1:0]                 b_resp;
        logic                       b_valid;
        logic                       ar_ready;
        logic [AXIS_ID_R_WIDTH-1:0] r_id;
        logic [AXIS_DATA_WIDTH-1:0] r_data;
        logic [1:0]                 r_resp;
        logic                       r_last;
        logic                       r_valid;
    } axis_miso_t;
endpackage

module axi_traffic_master
    import axis_pkg::*;
#(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [((ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH)-1:0] cmd_id_i,
    input  logic [DATA_WIDTH-1:0] cmd_seed_i,
    output axis_mosi_t            out_mosi_o,
    input  axis_miso_t            out_miso_i,
    output logic                  done_o,
    output logic [1:0]            resp_o,
    output logic [15:0]           err_cnt_o,
    output logic                  proto_err_o
);
    localparam int ID_WIDTH   = (ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH;
    localparam int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [2:0] AXSIZE     = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    // Pattern value of the current beat (seed + k); wraps naturally mod 2^DATA_WIDTH.
    logic [DATA_WIDTH-1:0] data_q, data_d;
    // Bit 8 saturates so overrun beats never alias back onto len.
    logic [8:0]            beat_q, beat_d;
    logic [1:0]            resp_q, resp_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  proto_err_q, proto_err_d;

    logic                  beat_is_last;
    logic [8:0]            beat_inc;
    logic [DATA_WIDTH-1:0] data_inc;

    assign beat_is_last = (beat_q == {1'b0, len_q});
    assign beat_inc     = beat_q[8] ? beat_q : beat_q + 9'd1;
    assign data_inc     = data_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        id_d        = id_q;
        data_d      = data_q;
        beat_d      = beat_q;
        resp_d      = resp_q;
        err_cnt_d   = err_cnt_q;
        proto_err_d = proto_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d      = cmd_addr_i;
                    len_d       = cmd_len_i;
                    id_d        = cmd_id_i;
                    data_d      = cmd_seed_i;
                    beat_d      = 9'd0;
                    resp_d      = 2'b00;
                    err_cnt_d   = 16'd0;
                    proto_err_d = 1'b0;
                    state_d     = cmd_write_i ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                if (out_miso_i.aw_ready) state_d = ST_W;
            end
            ST_W: begin
                if (out_miso_i.w_ready) begin
                    data_d = data_inc;
                    beat_d = beat_inc;
                    if (beat_is_last) state_d = ST_B;
                end
            end
            ST_B: begin
                if (out_miso_i.b_valid) begin
                    resp_d = out_miso_i.b_resp;
                    if (out_miso_i.b_id != id_q[ID_W_WIDTH-1:0]) proto_err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_AR: begin
                if (out_miso_i.ar_ready) state_d = ST_R;
            end
            ST_R: begin
                if (out_miso_i.r_valid) begin
                    if ((out_miso_i.r_data != data_q) && (err_cnt_q != 16'hFFFF))
                        err_cnt_d = err_cnt_q + 16'd1;
                    if (out_miso_i.r_resp > resp_q) resp_d = out_miso_i.r_resp;
                    if ((out_miso_i.r_id != id_q[ID_R_WIDTH-1:0]) ||
                        (out_miso_i.r_last != beat_is_last))
                        proto_err_d = 1'b1;
                    data_d = data_inc;
                    beat_d = beat_inc;
                    // An early RLAST still terminates the burst; it is only flagged.
                    if (out_miso_i.r_last) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            data_q      <= '0;
            beat_q      <= '0;
            resp_q      <= '0;
            err_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            id_q        <= id_d;
            data_q      <= data_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            err_cnt_q   <= err_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Handshake outputs decode the state register only, so an async reset drops them at once.
    always_comb begin
        out_mosi_o          = '0;
        out_mosi_o.aw_id    = id_q[ID_W_WIDTH-1:0];
        out_mosi_o.aw_addr  = addr_q;
        out_mosi_o.aw_len   = len_q;
        out_mosi_o.aw_size  = AXSIZE;
        out_mosi_o.aw_burst = BURST_INCR;
        out_mosi_o.aw_valid = (state_q == ST_AW);
        out_mosi_o.w_data   = data_q;
        out_mosi_o.w_strb   = {STRB_WIDTH{1'b1}};
        out_mosi_o.w_last   = beat_is_last;
        out_mosi_o.w_valid  = (state_q == ST_W);
        out_mosi_o.b_ready  = (state_q == ST_B);
        out_mosi_o.ar_id    = id_q[ID_R_WIDTH-1:0];
        out_mosi_o.ar_addr  = addr_q;
        out_mosi_o.ar_len   = len_q;
        out_mosi_o.ar_size  = AXSIZE;
        out_mosi_o.ar_burst = BURST_INCR;
        out_mosi_o.ar_valid = (state_q == ST_AR);
        out_mosi_o.r_ready  = (state_q == ST_R);
    end

    assign cmd_ready_o = (state_q == ST_IDLE) && !rst_in;
    assign done_o      = (state_q == ST_DONE);
    assign resp_o      = resp_q;
    assign err_cnt_o   = err_cnt_q;
    assign proto_err_o = proto_err_q;

endmodule
